traffic_phase_controller: RTL and testbench

- Parametrised successor to the two-road intersection controller: serves NUM_PHASES approaches (default 4) in round-robin order, one approach green at a time.
- Actuated timing: minimum green, gap-out on competing demand, maximum green, fixed yellow and all-red clearance intervals.
- All timing runs on an external one-cycle `tick` strobe (board 1 Hz divider), not on raw clk counts.
- Sits between the sensor synchronisers and the LED/lamp drivers.

---
 rtl/traffic_phase_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// Round-robin actuated traffic phase controller for NUM_PHASES approaches, paced by an external tick.
// Optional flashing-red mode is compiled in with `define TRAFFIC_FLASH_EN (adds input flash).
module traffic_phase_controller #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 5,
    parameter int STARTUP_T  = 1,
    parameter int MIN_GREEN  = 5,
    parameter int MAX_GREEN  = 10,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NUM_PHASES-1:0]   sensor,
`ifdef TRAFFIC_FLASH_EN
    input  logic                    flash,
`endif
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [2:0]              active_phase,
    output logic [NUM_PHASES-1:0]   demand,
    output logic                    phase_start,
    output logic [2:0]              o_state
);

    localparam logic [2:0] S_STARTUP = 3'd0;
    localparam logic [2:0] S_ALL_RED = 3'd1;
    localparam logic [2:0] S_GREEN   = 3'd2;
    localparam logic [2:0] S_YELLOW  = 3'd3;
`ifdef TRAFFIC_FLASH_EN
    localparam logic [2:0] S_FLASH   = 3'd4;
`endif

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_T - 1);
    localparam logic [CNT_W-1:0] MIN_LAST     = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST     = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST  = CNT_W'(ALLRED_T - 1);

    localparam logic [3:0]            NP4      = 4'(NUM_PHASES);
    localparam logic [2:0]            LAST_PH  = 3'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] ONE_BIT  = {{(NUM_PHASES-1){1'b0}}, 1'b1};

    // Registered state
    logic [2:0]              r_state;
    logic [CNT_W-1:0]        r_timer;
    logic                    r_expired;
    logic                    r_armed;
    logic [2:0]              r_active;
    logic [NUM_PHASES-1:0]   r_demand;
    logic [3*NUM_PHASES-1:0] r_lights;
    logic                    r_phase_start;
`ifdef TRAFFIC_FLASH_EN
    logic                    r_flash_red;
    logic                    w_flash_red_nxt;
`endif

    // Combinational next-state signals
    logic                    w_tick;
    logic [NUM_PHASES-1:0]   w_active_oh;
    logic                    w_sensor_active;
    logic                    w_other_demand;
    logic [2:0]              w_sel;
    logic                    w_found;
    logic [3:0]              w_idx;
    logic [CNT_W-1:0]        w_limit;
    logic                    w_bad;
    logic                    w_active_bad;
    logic [2:0]              w_state_nxt;
    logic [CNT_W-1:0]        w_timer_nxt;
    logic                    w_expired_nxt;
    logic [2:0]              w_active_nxt;
    logic                    w_enter_green;
    logic [NUM_PHASES-1:0]   w_green_mask;
    logic [NUM_PHASES-1:0]   w_clear_mask;
    logic [NUM_PHASES-1:0]   w_demand_nxt;
    logic [3*NUM_PHASES-1:0] w_lights_nxt;

    // A tick coinciding with the first edge after reset release is not counted.
    assign w_tick          = tick & r_armed;
    assign w_active_oh     = ONE_BIT << r_active;
    assign w_sensor_active = |(sensor & w_active_oh);
    assign w_other_demand  = |(r_demand & ~w_active_oh);
    assign w_active_bad    = ({1'b0, r_active} >= NP4);

    always_comb begin
        w_sel   = (r_active == LAST_PH) ? 3'd0 : r_active + 3'd1;
        w_found = 1'b0;
        w_idx   = 4'd0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            w_idx = {1'b0, r_active} + 4'(k);
            if (w_idx >= NP4) begin
                w_idx = w_idx - NP4;
            end
            if (!w_found && (|(r_demand & (ONE_BIT << w_idx)))) begin
                w_found = 1'b1;
                w_sel   = w_idx[2:0];
            end
        end
    end

    always_comb begin
        case (r_state)
            S_STARTUP: w_limit = STARTUP_LAST;
            S_ALL_RED: w_limit = ALLRED_LAST;
            S_GREEN:   w_limit = MAX_LAST;
            S_YELLOW:  w_limit = YELLOW_LAST;
            default:   w_limit = '0;
        endcase
        w_bad = (r_timer > w_limit) || w_active_bad;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = w_tick ? r_timer + 1'b1 : r_timer;
        w_expired_nxt   = r_expired;
        w_active_nxt    = r_active;
        w_enter_green   = 1'b0;
`ifdef TRAFFIC_FLASH_EN
        w_flash_red_nxt = r_flash_red;
`endif
        case (r_state)
            S_STARTUP: begin
                if (w_tick && r_timer == STARTUP_LAST) begin
                    w_state_nxt   = S_ALL_RED;
                    w_timer_nxt   = '0;
                    w_expired_nxt = 1'b1;
                end
            end
            S_ALL_RED: begin
                if (r_expired || (w_tick && r_timer == ALLRED_LAST)) begin
                    w_timer_nxt   = '0;
                    w_expired_nxt = 1'b0;
`ifdef TRAFFIC_FLASH_EN
                    if (flash) begin
                        w_state_nxt     = S_FLASH;
                        w_flash_red_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_GREEN;
                        w_active_nxt  = w_sel;
                        w_enter_green = 1'b1;
                    end
`else
                    w_state_nxt   = S_GREEN;
                    w_active_nxt  = w_sel;
                    w_enter_green = 1'b1;
`endif
                end
            end
            S_GREEN: begin
                // Gap-out once min green is served and another approach waits; max-out regardless.
                if (w_tick && (r_timer == MAX_LAST ||
                               (r_timer >= MIN_LAST && !w_sensor_active && w_other_demand))) begin
                    w_state_nxt = S_YELLOW;
                    w_timer_nxt = '0;
                end
            end
            S_YELLOW: begin
                if (w_tick && r_timer == YELLOW_LAST) begin
                    w_state_nxt = S_ALL_RED;
                    w_timer_nxt = '0;
                end
            end
`ifdef TRAFFIC_FLASH_EN
            S_FLASH: begin
                w_timer_nxt = '0;
                if (w_tick) begin
                    if (!flash) begin
                        w_state_nxt = S_ALL_RED;
                    end else begin
                        w_flash_red_nxt = ~r_flash_red;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt   = S_ALL_RED;
                w_timer_nxt   = '0;
                w_expired_nxt = 1'b0;
            end
        endcase
        // Corrupted timer or phase index: fall back to a full all-red clearance.
        if (w_bad) begin
            w_state_nxt   = S_ALL_RED;
            w_timer_nxt   = '0;
            w_expired_nxt = 1'b0;
            w_enter_green = 1'b0;
            w_active_nxt  = w_active_bad ? LAST_PH : r_active;
        end
    end

    assign w_green_mask = (r_state == S_GREEN) ? w_active_oh : '0;
    assign w_clear_mask = w_enter_green ? (ONE_BIT << w_active_nxt) : '0;
    assign w_demand_nxt = (r_demand | (sensor & ~w_green_mask)) & ~w_clear_mask;

    always_comb begin
        w_lights_nxt = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            w_lights_nxt[3*i +: 3] = LAMP_RED;
            if (w_active_nxt == 3'(i)) begin
                if (w_state_nxt == S_GREEN) begin
                    w_lights_nxt[3*i +: 3] = LAMP_GREEN;
                end else if (w_state_nxt == S_YELLOW) begin
                    w_lights_nxt[3*i +: 3] = LAMP_YELLOW;
                end
            end
`ifdef TRAFFIC_FLASH_EN
            if (w_state_nxt == S_FLASH && !w_flash_red_nxt) begin
                w_lights_nxt[3*i +: 3] = 3'b000;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_STARTUP;
            r_timer       <= '0;
            r_expired     <= 1'b0;
            r_armed       <= 1'b0;
            r_active      <= LAST_PH;
            r_demand      <= '0;
            r_lights      <= {NUM_PHASES{LAMP_RED}};
            r_phase_start <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            r_flash_red   <= 1'b1;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_expired     <= w_expired_nxt;
            r_armed       <= 1'b1;
            r_active      <= w_active_nxt;
            r_demand      <= w_demand_nxt;
            r_lights      <= w_lights_nxt;
            r_phase_start <= w_enter_green;
`ifdef TRAFFIC_FLASH_EN
            r_flash_red   <= w_flash_red_nxt;
`endif
        end
    end

    assign lights       = r_lights;
    assign active_phase = r_active;
    assign demand       = r_demand;
    assign phase_start  = r_phase_start;
    assign o_state      = r_state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed and randomised checks of traffic_phase_controller with default parameters.
module tb_traffic_phase_controller;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [3:0]  sensor;
`ifdef TRAFFIC_FLASH_EN
    logic        flash;
`endif
    logic [11:0] lights;
    logic [2:0]  active_phase;
    logic [3:0]  demand;
    logic        phase_start;
    logic [2:0]  o_state;

    int n_tests;
    int n_fail;

    localparam logic [11:0] ALL_RED_L = 12'h924;

    traffic_phase_controller dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .sensor       (sensor),
`ifdef TRAFFIC_FLASH_EN
        .flash        (flash),
`endif
        .lights       (lights),
        .active_phase (active_phase),
        .demand       (demand),
        .phase_start  (phase_start),
        .o_state      (o_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given tick value; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    logic [11:0] prev_l;
    int          nonred;
    logic        seq_ok;
    logic        new_green;
    logic [2:0]  f_now;
    logic [2:0]  f_prev;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        tick    = 1'b0;
        sensor  = 4'b0000;
`ifdef TRAFFIC_FLASH_EN
        flash   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_lights", 32'(lights), 32'(ALL_RED_L));
        check_eq("rst_active", 32'(active_phase), 32'd3);
        check_eq("rst_demand", 32'(demand), 32'd0);
        check_eq("rst_pstart", 32'(phase_start), 32'd0);
        check_eq("rst_state", 32'(o_state), 32'd0);

        // Release reset with tick already high: that first tick must be ignored.
        rst = 1'b1;
        cyc(1'b1);
        check_eq("ign_tick_state", 32'(o_state), 32'd0);
        cyc(1'b1);
        check_eq("startup_done", 32'(o_state), 32'd1);
        check_eq("startup_red", 32'(lights), 32'(ALL_RED_L));
        cyc(1'b0);
        check_eq("p0_green", 32'(lights), 32'h921);
        check_eq("p0_active", 32'(active_phase), 32'd0);
        check_eq("p0_pstart", 32'(phase_start), 32'd1);

        // No demand: phase 0 holds to max green.
        cyc(1'b1);
        check_eq("p0_pstart_once", 32'(phase_start), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            cyc(1'b0);
            cyc(1'b1);
        end
        check_eq("p0_green_t9", 32'(lights), 32'h921);
        cyc(1'b1);
        check_eq("p0_yellow_t10", 32'(lights), 32'h922);
        cyc(1'b1);
        check_eq("p0_yellow_1", 32'(lights), 32'h922);
        cyc(1'b1);
        check_eq("p0_allred", 32'(lights), 32'(ALL_RED_L));
        cyc(1'b0);
        check_eq("allred_hold_no_tick", 32'(lights), 32'(ALL_RED_L));
        cyc(1'b1);
        check_eq("p1_green", 32'(lights), 32'h90C);
        check_eq("p1_active", 32'(active_phase), 32'd1);
        check_eq("p1_pstart", 32'(phase_start), 32'd1);

        // Gap-out: phase 3 calls at tick 2, phase 1 sensor idle.
        cyc(1'b1);
        sensor = 4'b1000;
        cyc(1'b1);
        sensor = 4'b0000;
        check_eq("gap_demand_set", 32'(demand), 32'b1000);
        cyc(1'b1);
        cyc(1'b1);
        check_eq("gap_green_t4", 32'(lights), 32'h90C);
        cyc(1'b1);
        check_eq("gap_yellow_t5", 32'(lights), 32'h914);
        cyc(1'b1);
        cyc(1'b1);
        check_eq("gap_allred", 32'(lights), 32'(ALL_RED_L));
        check_eq("gap_demand_hold", 32'(demand), 32'b1000);
        cyc(1'b1);
        check_eq("p3_green_skip", 32'(lights), 32'h324);
        check_eq("p3_active", 32'(active_phase), 32'd3);
        check_eq("p3_demand_clr", 32'(demand), 32'd0);

        // Own sensor held with a competing call: runs to max-out.
        sensor = 4'b1001;
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1);
        end
        check_eq("max_green_t9", 32'(lights), 32'h324);
        check_eq("max_own_no_demand", 32'(demand), 32'b0001);
        cyc(1'b1);
        check_eq("max_yellow", 32'(lights), 32'h524);
        cyc(1'b1);
        check_eq("yellow_sets_own", 32'(demand), 32'b1001);

        // Asynchronous reset during yellow of phase 3.
        rst = 1'b0;
        #1;
        check_eq("async_rst_lights", 32'(lights), 32'(ALL_RED_L));
        check_eq("async_rst_state", 32'(o_state), 32'd0);
        check_eq("async_rst_demand", 32'(demand), 32'd0);
        sensor = 4'b0000;
        cyc(1'b0);
        rst = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        check_eq("restart_allred", 32'(o_state), 32'd1);
        cyc(1'b0);
        check_eq("restart_p0", 32'(lights), 32'h921);
        check_eq("restart_active", 32'(active_phase), 32'd0);

        // Random stream: safety and lamp sequencing on every cycle.
        prev_l = lights;
        for (int c = 0; c < 3000; c++) begin
            sensor = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)));
            nonred    = 0;
            seq_ok    = 1'b1;
            new_green = 1'b0;
            for (int p = 0; p < 4; p++) begin
                f_now  = lights[3*p +: 3];
                f_prev = prev_l[3*p +: 3];
                if (f_now != 3'b100) nonred++;
                if (f_prev == 3'b001 && !(f_now == 3'b001 || f_now == 3'b010)) seq_ok = 1'b0;
                if (f_prev == 3'b010 && !(f_now == 3'b010 || f_now == 3'b100)) seq_ok = 1'b0;
                if (f_prev == 3'b100 && f_now == 3'b010) seq_ok = 1'b0;
                if (f_now == 3'b001 && f_prev != 3'b001) new_green = 1'b1;
            end
            if (nonred > 0 && prev_l != ALL_RED_L && new_green) seq_ok = 1'b0;
            check_eq("rand_one_nonred", 32'(nonred <= 1), 32'd1);
            check_eq("rand_sequence", 32'(seq_ok), 32'd1);
            check_eq("rand_pstart", 32'(phase_start), 32'(new_green));
            prev_l = lights;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
